// File: rtl/multicycle_cu.sv
// multicycle_cu: RV32I multi-cycle control unit sequencing FETCH/DECODE/EXEC/MEM/WB
// Ports:
//   clk, reset (async, active-low)
//   imem_ack/instr    : instruction fetch handshake response
//   dmem_ack, alu_cmp : data memory completion, branch condition from ALU
//   imem_req, dmem_req, dm_we                  : memory requests
//   rf_we, pc_write, pc_sel, op1_sel, op2_sel  : datapath control
//   wb_sel, func3, subsra                      : datapath control
//   rs1, rs2, rd                               : register fields from IR
//   illegal, timeout  : sticky faults
//   retired_cnt       : completed instructions
//   state             : current FSM state
module multicycle_cu #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter bit CNT_EN      = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            imem_ack,
  input  logic [31:0]     instr,
  input  logic            dmem_ack,
  input  logic            alu_cmp,
  output logic            imem_req,
  output logic            dmem_req,
  output logic            dm_we,
  output logic            rf_we,
  output logic            pc_write,
  output logic [1:0]      pc_sel,
  output logic            op1_sel,
  output logic            op2_sel,
  output logic [1:0]      wb_sel,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [2:0]      func3,
  output logic            subsra,
  output logic            illegal,
  output logic            timeout,
  output logic [XLEN-1:0] retired_cnt,
  output logic [2:0]      state
);
  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_DEC   = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd7;
  localparam logic [7:0] WAIT_MAX = 8'(MEM_TIMEOUT - 1);
  logic [31:0] ir;
  logic [2:0]  state_nx;
  logic [7:0]  wait_cnt;
  logic        run;
  logic        taken;
  logic        is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_aui;
  logic        legal, wr_op, rs1_op, addr_op;
  logic        waiting, expire, in_wb, in_x, br_t;
  logic        unused_ir;
  assign is_r    = ir[6:0] == 7'b0110011;
  assign is_i    = ir[6:0] == 7'b0010011;
  assign is_ld   = ir[6:0] == 7'b0000011;
  assign is_st   = ir[6:0] == 7'b0100011;
  assign is_br   = ir[6:0] == 7'b1100011;
  assign is_jal  = ir[6:0] == 7'b1101111;
  assign is_jalr = ir[6:0] == 7'b1100111;
  assign is_lui  = ir[6:0] == 7'b0110111;
  assign is_aui  = ir[6:0] == 7'b0010111;
  assign legal   = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_aui;
  assign wr_op   = is_r | is_i | is_ld | is_jal | is_jalr | is_lui | is_aui;
  assign rs1_op  = is_r | is_i | is_ld | is_st | is_jalr | is_br;
  // ops whose ALU use is an address/target add rather than a func3-selected function
  assign addr_op = is_ld | is_st | is_jal | is_jalr | is_aui | is_lui;
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign rd  = ir[11:7];
  assign unused_ir = ^{ir[31], ir[29:25]};
  // run holds requests low until the first edge after reset release
  assign waiting = run && (state == S_FETCH || state == S_MEM);
  // the last allowed wait cycle: no ack now means the count reaches MEM_TIMEOUT
  assign expire  = wait_cnt == WAIT_MAX;
  assign in_wb   = state == S_WB;
  assign in_x    = state == S_EXEC || state == S_MEM || state == S_WB;
  // taken branch reuses the ALU in WB for pc + imm
  assign br_t    = in_wb && is_br && taken;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_FETCH;
    else state <= state_nx;
  always_comb begin
    state_nx = S_HALT;
    case (state)
      S_FETCH: state_nx = !run ? S_FETCH : imem_ack ? S_DEC : expire ? S_HALT : S_FETCH;
      S_DEC:   state_nx = legal ? S_EXEC : S_HALT;
      S_EXEC:  state_nx = (is_ld || is_st) ? S_MEM : S_WB;
      S_MEM:   state_nx = dmem_ack ? S_WB : expire ? S_HALT : S_MEM;
      S_WB:    state_nx = S_FETCH;
      default: state_nx = S_HALT;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      run         <= 1'b0;
      ir          <= '0;
      taken       <= 1'b0;
      wait_cnt    <= '0;
      illegal     <= 1'b0;
      timeout     <= 1'b0;
      retired_cnt <= '0;
    end else begin
      run <= 1'b1;
      if (state == S_FETCH && run && imem_ack) ir <= instr;
      if (state == S_EXEC) taken <= is_br && alu_cmp;
      // any state change clears the count, so entry to FETCH or MEM starts at 0
      wait_cnt <= (state_nx != state) ? 8'd0 : waiting ? wait_cnt + 8'd1 : wait_cnt;
      if (state == S_DEC && !legal) illegal <= 1'b1;
      if (waiting && state_nx == S_HALT) timeout <= 1'b1;
      if (CNT_EN && in_wb) retired_cnt <= retired_cnt + XLEN'(1);
    end
  always_comb begin
    imem_req = run && state == S_FETCH;
    dmem_req = state == S_MEM;
    dm_we    = state == S_MEM && is_st;
    rf_we    = in_wb && wr_op && ir[11:7] != 5'd0;
    pc_write = in_wb;
    pc_sel   = !in_wb ? 2'b00 : is_jal ? 2'b01 : is_jalr ? 2'b10 : br_t ? 2'b01 : 2'b00;
    wb_sel   = !in_wb ? 2'b00 : is_ld ? 2'b00 : (is_jal || is_jalr) ? 2'b10 : is_lui ? 2'b11 : 2'b01;
    op1_sel  = in_x && rs1_op && !br_t;
    op2_sel  = in_x && (is_i || is_ld || is_st || is_jal || is_jalr || is_aui || br_t);
    // MEM hands the true func3 to the data memory for access width
    func3    = (in_x && state != S_MEM && (addr_op || br_t)) ? 3'b000 : ir[14:12];
    subsra   = (is_r || (is_i && ir[14:12] == 3'b101)) && ir[30];
  end
endmodule

// File: tb/tb_multicycle_cu.sv
// tb_multicycle_cu: table-driven scoreboard bench for multicycle_cu
module tb_multicycle_cu;
  logic        clk = 1'b0, reset = 1'b0;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0, alu_cmp = 1'b0;
  logic [31:0] instr = '0;
  logic        imem_req, dmem_req, dm_we, rf_we, pc_write, op1_sel, op2_sel, subsra;
  logic        illegal, timeout;
  logic [1:0]  pc_sel, wb_sel;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  func3, state;
  logic [31:0] retired_cnt;
  always #5 clk = ~clk;
  multicycle_cu #(.XLEN(32), .MEM_TIMEOUT(4), .CNT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .imem_ack(imem_ack), .instr(instr), .dmem_ack(dmem_ack),
    .alu_cmp(alu_cmp), .imem_req(imem_req), .dmem_req(dmem_req), .dm_we(dm_we),
    .rf_we(rf_we), .pc_write(pc_write), .pc_sel(pc_sel), .op1_sel(op1_sel),
    .op2_sel(op2_sel), .wb_sel(wb_sel), .rs1(rs1), .rs2(rs2), .rd(rd), .func3(func3),
    .subsra(subsra), .illegal(illegal), .timeout(timeout), .retired_cnt(retired_cnt),
    .state(state)
  );
  typedef struct {
    logic [31:0] ins;
    int          iw;
    int          dw;
    bit          cmp;
    bit          mem;
    bit          we;
    logic [4:0]  rd;
    logic [1:0]  wb;
    logic [1:0]  pc;
    bit          sub;
  } vec_t;
  typedef struct {
    bit          we;
    bit          dwe;
    logic [4:0]  rd;
    logic [1:0]  wb;
    logic [1:0]  pc;
    bit          sub;
    logic [2:0]  f3;
    int          lat;
    int          dcyc;
  } exp_t;
  exp_t        q[$];
  exp_t        em;
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, dcyc = 0, wec = 0;
  bit          dwe_seen = 1'b0;
  logic [31:0] cnt_m = '0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask
  // scoreboard monitor: accumulates per-instruction activity, checks at the WB pulse
  always @(negedge clk) begin
    if (!reset) begin
      cyc = 0; dcyc = 0; wec = 0; dwe_seen = 1'b0; cnt_m = '0;
    end else begin
      if (cyc == 0 && imem_req) cyc = 1;
      else if (cyc > 0) cyc++;
      if (dmem_req) begin
        dcyc++;
        if (dm_we) dwe_seen = 1'b1;
        if (q.size() > 0) chk("mem_func3", func3, q[0].f3);
      end
      if (rf_we) wec++;
      if (pc_write || rf_we) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_wb: pc_write=%0b rf_we=%0b with nothing outstanding", pc_write, rf_we);
        end else begin
          em = q.pop_front();
          chk("latency", cyc, em.lat);
          chk("dmem_cycles", dcyc, em.dcyc);
          chk("dm_we", dwe_seen, em.dwe);
          chk("rf_we_pulses", wec, em.we ? 1 : 0);
          chk("pc_write", pc_write, 1);
          chk("pc_sel", pc_sel, em.pc);
          chk("subsra", subsra, em.sub);
          chk("retired_cnt", retired_cnt, cnt_m);
          chk("faults", {illegal, timeout}, 2'b00);
          if (em.we) begin
            chk("rd", rd, em.rd);
            chk("wb_sel", wb_sel, em.wb);
          end
          if (em.pc == 2'b01) chk("tgt_pc_imm", {op1_sel, op2_sel, func3}, 5'b01_000);
          if (em.pc == 2'b10) chk("tgt_rs1_imm", {op1_sel, op2_sel, func3}, 5'b11_000);
        end
        cnt_m++;
        cyc = 0; dcyc = 0; wec = 0; dwe_seen = 1'b0;
      end
    end
  end
  task automatic wait_req(input bit d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((d ? dmem_req : imem_req) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_req_wait: request not seen within 40 cycles", d ? "dmem" : "imem");
    end
  endtask
  // called at the negedge where the request is first seen; ack rises after w wait cycles
  task automatic handshake(input bit d, input int w);
    for (int i = 0; i < w; i++) @(negedge clk);
    if (d) dmem_ack = 1'b1; else imem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    imem_ack = 1'b0;
  endtask
  task automatic apply(input vec_t v);
    exp_t e;
    bit   ok;
    e.we   = v.we;
    e.dwe  = v.ins[6:0] == 7'b0100011;
    e.rd   = v.rd;
    e.wb   = v.wb;
    e.pc   = v.pc;
    e.sub  = v.sub;
    e.f3   = v.ins[14:12];
    e.dcyc = v.mem ? 1 + v.dw : 0;
    e.lat  = 4 + v.iw + e.dcyc;
    q.push_back(e);
    instr = v.ins;
    wait_req(1'b0, ok);
    if (!ok) return;
    handshake(1'b0, v.iw);
    alu_cmp = v.cmp;
    if (v.mem) begin
      wait_req(1'b1, ok);
      if (ok) handshake(1'b1, v.dw);
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
  endtask
  vec_t tbl[16];
  initial begin
    bit ok;
    int held;
    //           ins           iw dw cmp mem we rd  wb     pc     sub
    tbl[0]  = '{32'h002081B3, 0, 0, 0, 0, 1, 3, 2'b01, 2'b00, 0};
    tbl[1]  = '{32'h0080A283, 0, 3, 0, 1, 1, 5, 2'b00, 2'b00, 0};
    tbl[2]  = '{32'h0020A023, 2, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0};
    tbl[3]  = '{32'h00208463, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 0};
    tbl[4]  = '{32'h00208463, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0};
    tbl[5]  = '{32'h000100E7, 0, 0, 0, 0, 1, 1, 2'b10, 2'b10, 0};
    tbl[6]  = '{32'h00500013, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0};
    tbl[7]  = '{32'h010000EF, 0, 0, 0, 0, 1, 1, 2'b10, 2'b01, 0};
    tbl[8]  = '{32'h123453B7, 0, 0, 0, 0, 1, 7, 2'b11, 2'b00, 0};
    tbl[9]  = '{32'h00001497, 0, 0, 0, 0, 1, 9, 2'b01, 2'b00, 0};
    tbl[10] = '{32'h00008303, 3, 3, 0, 1, 1, 6, 2'b00, 2'b00, 0};
    tbl[11] = '{32'h4030D213, 0, 0, 0, 0, 1, 4, 2'b01, 2'b00, 1};
    tbl[12] = '{32'h40208233, 0, 0, 0, 0, 1, 4, 2'b01, 2'b00, 1};
    tbl[13] = '{32'hC0008213, 0, 0, 0, 0, 1, 4, 2'b01, 2'b00, 0};
    tbl[14] = '{32'h00209123, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0};
    tbl[15] = '{32'h00209463, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 0};
    repeat (3) @(negedge clk);
    chk("rst_state", state, 3'd0);
    chk("rst_reqs", {imem_req, dmem_req, dm_we}, 3'b000);
    chk("rst_pulses", {rf_we, pc_write}, 2'b00);
    chk("rst_flags", {illegal, timeout}, 2'b00);
    chk("rst_retired", retired_cnt, 0);
    chk("rst_ir_fields", {rs1, rs2, rd, func3}, 0);
    reset = 1'b1;
    #1 chk("imem_req_before_edge", imem_req, 1'b0);
    for (int i = 0; i < 16; i++) apply(tbl[i]);
    drain();
    @(negedge clk);
    chk("retired_total", retired_cnt, 16);
    // unsupported opcode halts until reset
    instr = 32'h0000007F;
    wait_req(1'b0, ok);
    if (ok) handshake(1'b0, 0);
    @(negedge clk);
    chk("illegal_set", {illegal, state}, {1'b1, 3'd7});
    held = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state == 3'd7 && !imem_req && !dmem_req && !pc_write && !rf_we) held++;
    end
    chk("halt_hold", held, 20);
    chk("halt_cnt_frozen", retired_cnt, 16);
    #2 reset = 1'b0;
    #1 chk("halt_reset", {illegal, state, imem_req}, 5'b0);
    @(negedge clk);
    reset = 1'b1;
    // fetch ack withheld: fault after the 4th wait cycle
    wait_req(1'b0, ok);
    repeat (3) @(negedge clk);
    chk("fetch_last_wait", {timeout, imem_req, state}, {1'b0, 1'b1, 3'd0});
    @(negedge clk);
    chk("fetch_timeout", {timeout, imem_req, state}, {1'b1, 1'b0, 3'd7});
    reset = 1'b0;
    @(negedge clk);
    chk("timeout_cleared", timeout, 1'b0);
    reset = 1'b1;
    // ack on the last allowed wait cycle wins
    apply('{32'h002081B3, 3, 0, 0, 0, 1, 3, 2'b01, 2'b00, 0});
    chk("ack_at_limit", {timeout, state}, {1'b0, 3'd1});
    drain();
    // data ack withheld on a load
    instr = 32'h0080A283;
    wait_req(1'b0, ok);
    if (ok) handshake(1'b0, 0);
    wait_req(1'b1, ok);
    repeat (3) @(negedge clk);
    chk("dmem_last_wait", {timeout, dmem_req, dm_we}, 3'b010);
    @(negedge clk);
    chk("dmem_timeout", {timeout, dmem_req, state}, {1'b1, 1'b0, 3'd7});
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    // reset in the middle of a store's MEM state
    instr = 32'h0020A023;
    wait_req(1'b0, ok);
    if (ok) handshake(1'b0, 0);
    wait_req(1'b1, ok);
    chk("store_dm_we", {dmem_req, dm_we}, 2'b11);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("mid_mem_reset", {dmem_req, dm_we, state}, 5'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("aborted_no_retire", retired_cnt, 0);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
